imem_line_buffer: RTL and testbench
===================================

Name: imem_line_buffer

Overview:
Single-line instruction buffer directly upstream of the fetch stage.
- Serves fetch's instruction-memory requests (imem_address, imem_action_stb/cyc) with a full 128-bit line on imem_rdata plus imem_resp. The fetch stage selects the 16-bit word itself.
- On a miss, fetches the aligned line from physical memory over a simple read handshake, refills, then serves the hit.
- Gives fetch a deterministic response protocol independent of memory latency.

Parameters:
ADDR_WIDTH, 16, byte address width (lc3b_word).
LINE_BITS, 128, line width in bits. Offset width OFF_W = log2(LINE_BITS/8) = 4. Tag width TAG_W = ADDR_WIDTH-OFF_W = 12.

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
imem_address  in  16  fetch byte address (the PC)
imem_action_stb  in  1  request strobe
imem_action_cyc  in  1  bus cycle valid; a request is stb&cyc
invalidate  in  1  one-cycle pulse that discards the buffered line
imem_rdata  out  128  buffered line
imem_resp  out  1  hit response, combinational
pmem_address  out  16  line-aligned fill address, registered
pmem_read  out  1  fill request, registered
pmem_rdata  in  128  fill data
pmem_resp  in  1  fill data valid, single cycle

Behaviour:
- Reset (async, reset_n=0): state=IDLE; valid=0; drop=0; pmem_read=0; pmem_address=0; line data=0; tag=0. While valid=0, imem_rdata=0 and imem_resp=0.
- hit = valid & (tag == imem_address[15:4]) & stb & cyc & (state==IDLE) & !invalidate.
- imem_resp = hit, combinational in the same cycle. imem_rdata always drives the stored line.
- IDLE:
  - A request that is not a hit latches pmem_address = {imem_address[15:4], 4'b0} and sets pmem_read=1.
  - Next state is FILL.
  - Without a request, stay in IDLE.
- FILL:
  - pmem_read holds at 1 and pmem_address holds stable until pmem_resp.
  - On pmem_resp: pmem_read=0 and state=IDLE.
  - If drop=0, also write line=pmem_rdata, tag=pmem_address[15:4], valid=1.
  - Never respond to fetch while in FILL.
- Miss latency: the request is first seen in cycle 0; pmem_read rises in cycle 1; pmem_resp arrives in cycle k; imem_resp is asserted in cycle k+1 if the address is unchanged.
- invalidate:
  - Clears valid at the next edge.
  - Forces imem_resp=0 in the cycle it is asserted.
  - Asserted in FILL: sets drop=1, the returning line is discarded, and drop is cleared on pmem_resp.
  - Asserted in the same cycle as pmem_resp: the line is discarded.
- A fetch address change during FILL is legal. The fill still completes for the latched address. The new address is re-evaluated in IDLE and may miss again.
- pmem_resp outside FILL is ignored.
- Reset mid-fill drops the request immediately. A late pmem_resp is ignored.
- A request with stb=0 or cyc=0 never starts a fill.

Optional Feature:
ILB_PERF_CNT_EN:
- Defined:
  - Adds outputs hit_count[15:0] and miss_count[15:0], both reset to 0.
  - hit_count increments on each cycle with imem_resp=1.
  - miss_count increments on each IDLE->FILL transition.
  - Both saturate at 16'hFFFF.
  - Adds input perf_clear, which zeroes both counters synchronously and wins over any same-cycle increment.
- Undefined: these ports and registers do not exist, and behaviour is otherwise identical.

Decomposition:
- lc3b_types additions: lc3b_line_tag (logic [11:0]); lc3b_ilb_state_t enum {ILB_IDLE, ILB_FILL}; constant LC3B_LINE_OFF_W = 4. lc3b_data (128b) and lc3b_word are already present.
- Sub-module ilb_line_store: holds the valid/tag/data registers, takes write-enable and clear inputs, and outputs the tag-compare match. The FSM and pmem handshake stay in imem_line_buffer.

Test Plan:
1. Reset, then request 16'h0000 with stb=cyc=1. Require: cycle 1 pmem_read=1 and pmem_address=16'h0000. pmem_resp is given in cycle 4 with data 128'h0007_0006_..._0000. Require imem_resp=1 in cycle 5, and imem_rdata equal to that data.
2. After fill 1, request 16'h0002, then 16'h000E. Require imem_resp=1 in the same cycle for each with no pmem_read. Then request 16'h0010: require a miss, with pmem_address=16'h0010.
3. Assert invalidate in cycle 2 of a fill for 16'h0120, then return pmem_resp. Require valid=0 after the fill, imem_resp=0, and a new fill for 16'h0120 to start.
4. Change imem_address from 16'h0040 to 16'h0200 mid-fill. Require pmem_address to stay 16'h0040 and the line to be stored. The next IDLE cycle must miss and issue pmem_address=16'h0200.
5. Drop reset_n low while pmem_read=1. Require immediate pmem_read=0 and imem_resp=0. A stray pmem_resp after release must write nothing.
6. With ILB_PERF_CNT_EN: run 1 miss and 3 hits. Require miss_count=1 and hit_count=3. Preload near saturation: counters hold at FFFF. perf_clear must zero both.

Source files
------------

// File: rtl/imem_line_buffer_pkg.sv
// Shared types for the single-line instruction buffer (perf counters: ILB_PERF_CNT_EN).
// Line/tag geometry, FSM state enum and address helpers.
package imem_line_buffer_pkg;

  localparam int ADDR_WIDTH      = 16;
  localparam int LINE_BITS       = 128;
  localparam int LC3B_LINE_OFF_W = 4;
  localparam int TAG_W           = ADDR_WIDTH - LC3B_LINE_OFF_W;

  typedef logic [ADDR_WIDTH-1:0] lc3b_word;
  typedef logic [LINE_BITS-1:0]  lc3b_data;
  typedef logic [TAG_W-1:0]      lc3b_line_tag;

  typedef enum logic {
    ILB_IDLE,
    ILB_FILL
  } lc3b_ilb_state_t;

  function automatic lc3b_line_tag line_tag(input lc3b_word addr);
    return addr[ADDR_WIDTH-1:LC3B_LINE_OFF_W];
  endfunction

  function automatic lc3b_word line_base(input lc3b_word addr);
    return {addr[ADDR_WIDTH-1:LC3B_LINE_OFF_W], {LC3B_LINE_OFF_W{1'b0}}};
  endfunction

endpackage

// File: rtl/imem_line_buffer_if.sv
// Fetch-side and physical-memory-side signals of the line buffer (perf ports under ILB_PERF_CNT_EN).
// slave = the buffer itself, master = the fetch stage plus memory environment.
interface imem_line_buffer_if;
  import imem_line_buffer_pkg::*;

  lc3b_word imem_address;
  logic     imem_action_stb;
  logic     imem_action_cyc;
  logic     invalidate;
  lc3b_data imem_rdata;
  logic     imem_resp;
  lc3b_word pmem_address;
  logic     pmem_read;
  lc3b_data pmem_rdata;
  logic     pmem_resp;
`ifdef ILB_PERF_CNT_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
  logic        perf_clear;

  modport slave (
    input  imem_address, imem_action_stb, imem_action_cyc, invalidate,
    input  pmem_rdata, pmem_resp, perf_clear,
    output imem_rdata, imem_resp, pmem_address, pmem_read,
    output hit_count, miss_count
  );
  modport master (
    output imem_address, imem_action_stb, imem_action_cyc, invalidate,
    output pmem_rdata, pmem_resp, perf_clear,
    input  imem_rdata, imem_resp, pmem_address, pmem_read,
    input  hit_count, miss_count
  );
`else
  modport slave (
    input  imem_address, imem_action_stb, imem_action_cyc, invalidate,
    input  pmem_rdata, pmem_resp,
    output imem_rdata, imem_resp, pmem_address, pmem_read
  );
  modport master (
    output imem_address, imem_action_stb, imem_action_cyc, invalidate,
    output pmem_rdata, pmem_resp,
    input  imem_rdata, imem_resp, pmem_address, pmem_read
  );
`endif

endinterface

// File: rtl/imem_line_buffer_line_store.sv
// Valid/tag/data registers for the one buffered line plus the lookup tag compare.
// Clear beats a same-cycle write; the line reads as zero while invalid.
module ilb_line_store
  import imem_line_buffer_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_wr_en,
  input  lc3b_line_tag i_wr_tag,
  input  lc3b_data     i_wr_data,
  input  logic         i_clear,
  input  lc3b_line_tag i_lookup_tag,
  output logic         o_match,
  output lc3b_data     o_line
);

  logic         r_valid;
  lc3b_line_tag r_tag;
  lc3b_data     r_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_data  <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_wr_en) begin
      r_valid <= 1'b1;
      r_tag   <= i_wr_tag;
      r_data  <= i_wr_data;
    end
  end

  assign o_match = r_valid && (r_tag == i_lookup_tag);
  assign o_line  = r_valid ? r_data : '0;

endmodule

// File: rtl/imem_line_buffer.sv
// Single-line instruction buffer: combinational hit response, registered pmem fill on miss.
// Optional hit/miss counters with ILB_PERF_CNT_EN; no response is given while a fill is in flight.
module imem_line_buffer
  import imem_line_buffer_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  imem_line_buffer_if.slave  bus
);

  lc3b_ilb_state_t r_state;
  lc3b_ilb_state_t w_state_nxt;
  logic            r_drop;
  logic            r_pmem_read;
  lc3b_word        r_pmem_address;

  logic     w_req;
  logic     w_match;
  logic     w_hit;
  logic     w_start;
  logic     w_fill_done;
  logic     w_wr_en;
  lc3b_data w_line;

  assign w_req       = bus.imem_action_stb && bus.imem_action_cyc;
  assign w_hit       = w_match && w_req && (r_state == ILB_IDLE) && !bus.invalidate;
  assign w_start     = (r_state == ILB_IDLE) && w_req && !w_hit;
  assign w_fill_done = (r_state == ILB_FILL) && bus.pmem_resp;
  // A line is discarded if an invalidate landed anywhere during its fill, including the return cycle.
  assign w_wr_en     = w_fill_done && !r_drop && !bus.invalidate;

  ilb_line_store u_line_store (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_wr_en      (w_wr_en),
    .i_wr_tag     (line_tag(r_pmem_address)),
    .i_wr_data    (bus.pmem_rdata),
    .i_clear      (bus.invalidate),
    .i_lookup_tag (line_tag(bus.imem_address)),
    .o_match      (w_match),
    .o_line       (w_line)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ILB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ILB_IDLE: if (w_start)     w_state_nxt = ILB_FILL;
      ILB_FILL: if (w_fill_done) w_state_nxt = ILB_IDLE;
      default:                   w_state_nxt = ILB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pmem_read    <= 1'b0;
      r_pmem_address <= '0;
      r_drop         <= 1'b0;
    end else begin
      if (w_start) begin
        r_pmem_read    <= 1'b1;
        r_pmem_address <= line_base(bus.imem_address);
      end else if (w_fill_done) begin
        r_pmem_read    <= 1'b0;
      end

      if (w_fill_done) begin
        r_drop <= 1'b0;
      end else if ((r_state == ILB_FILL) && bus.invalidate) begin
        r_drop <= 1'b1;
      end
    end
  end

  assign bus.imem_resp    = w_hit;
  assign bus.imem_rdata   = w_line;
  assign bus.pmem_read    = r_pmem_read;
  assign bus.pmem_address = r_pmem_address;

`ifdef ILB_PERF_CNT_EN
  logic [15:0] r_hit_count;
  logic [15:0] r_miss_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else if (bus.perf_clear) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      if (w_hit && (r_hit_count != 16'hFFFF)) begin
        r_hit_count <= r_hit_count + 16'd1;
      end
      if (w_start && (r_miss_count != 16'hFFFF)) begin
        r_miss_count <= r_miss_count + 16'd1;
      end
    end
  end

  assign bus.hit_count  = r_hit_count;
  assign bus.miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_imem_line_buffer.sv
// Bench for imem_line_buffer: inputs driven 1ns after the rising edge, outputs sampled on the falling edge.
// Expected lines are queued whenever a hit is expected and popped by the response monitor.
module tb_imem_line_buffer;
  import imem_line_buffer_pkg::*;

  logic clk;
  logic reset_n;
  int   n_chk;
  int   n_pass;
  logic mon_en;
  logic [127:0] exp_q[$];

  imem_line_buffer_if bus();

  imem_line_buffer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
  endtask

  // Memory model: 16-bit word i of a line is (line index * 8 + i).
  function automatic logic [127:0] line_of(input logic [15:0] addr);
    logic [127:0] d;
    logic [15:0]  base;
    base = {1'b0, addr[15:4], 3'b000};
    d = '0;
    for (int i = 0; i < 8; i++) d[i*16 +: 16] = base + 16'(i);
    return d;
  endfunction

  always @(negedge clk) begin
    if (mon_en && reset_n && (bus.imem_resp === 1'b1)) begin
      if (exp_q.size() == 0) chk("sb_unexpected_resp", 128'(1), 128'(0));
      else chk("sb_rdata", bus.imem_rdata, exp_q.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic req(input logic [15:0] a);
    bus.imem_address    = a;
    bus.imem_action_stb = 1'b1;
    bus.imem_action_cyc = 1'b1;
  endtask

  task automatic idle_bus();
    bus.imem_action_stb = 1'b0;
    bus.imem_action_cyc = 1'b0;
  endtask

  task automatic expect_hit(input string tag, input logic [15:0] a);
    tick();
    req(a);
    exp_q.push_back(line_of(a));
    samp();
    chk({tag, "_resp"}, 128'(bus.imem_resp), 128'(1));
    chk({tag, "_no_pmem"}, 128'(bus.pmem_read), 128'(0));
  endtask

  // Request presented in cycle 0, pmem_resp returned in cycle lat (lat >= 2), hit expected in lat+1.
  task automatic miss_fill(input string tag, input logic [15:0] a, input int lat);
    tick();
    req(a);
    samp();
    chk({tag, "_miss"}, 128'(bus.imem_resp), 128'(0));
    tick();
    samp();
    chk({tag, "_pmem_read"}, 128'(bus.pmem_read), 128'(1));
    chk({tag, "_pmem_addr"}, 128'(bus.pmem_address), 128'(line_base(a)));
    for (int i = 2; i < lat; i++) begin
      tick();
      samp();
    end
    tick();
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = line_of(a);
    samp();
    chk({tag, "_no_resp_fill"}, 128'(bus.imem_resp), 128'(0));
    tick();
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
    exp_q.push_back(line_of(a));
    samp();
    chk({tag, "_hit_after"}, 128'(bus.imem_resp), 128'(1));
    chk({tag, "_read_low"}, 128'(bus.pmem_read), 128'(0));
  endtask

  initial begin
    n_chk   = 0;
    n_pass  = 0;
    mon_en  = 1'b1;
    reset_n = 1'b0;
    bus.imem_address    = '0;
    bus.imem_action_stb = 1'b0;
    bus.imem_action_cyc = 1'b0;
    bus.invalidate      = 1'b0;
    bus.pmem_rdata      = '0;
    bus.pmem_resp       = 1'b0;
`ifdef ILB_PERF_CNT_EN
    bus.perf_clear      = 1'b0;
`endif
    tick();
    tick();
    samp();
    chk("rst_resp", 128'(bus.imem_resp), 128'(0));
    chk("rst_rdata", bus.imem_rdata, 128'(0));
    chk("rst_pmem_read", 128'(bus.pmem_read), 128'(0));
    chk("rst_pmem_addr", 128'(bus.pmem_address), 128'(0));
    tick();
    reset_n = 1'b1;

    // First fill, then hits in the same line, then the next line misses.
    miss_fill("t1", 16'h0000, 4);
    expect_hit("t2_h2", 16'h0002);
    expect_hit("t2_hE", 16'h000E);
    miss_fill("t2_m10", 16'h0010, 3);

    // Incomplete strobe/cycle qualification must never start a fill.
    tick();
    bus.imem_address = 16'h0800;
    bus.imem_action_stb = 1'b1;
    bus.imem_action_cyc = 1'b0;
    samp();
    chk("gate_cyc_resp", 128'(bus.imem_resp), 128'(0));
    tick();
    bus.imem_action_stb = 1'b0;
    bus.imem_action_cyc = 1'b1;
    samp();
    chk("gate_cyc_read", 128'(bus.pmem_read), 128'(0));
    tick();
    idle_bus();
    samp();
    chk("gate_stb_read", 128'(bus.pmem_read), 128'(0));

    // Invalidate on what would be a hit: no response, refill starts.
    tick();
    req(16'h0014);
    bus.invalidate = 1'b1;
    samp();
    chk("t3_inv_hit_resp", 128'(bus.imem_resp), 128'(0));
    tick();
    bus.invalidate = 1'b0;
    samp();
    chk("t3_inv_refill_read", 128'(bus.pmem_read), 128'(1));
    chk("t3_inv_refill_addr", 128'(bus.pmem_address), 128'(16'h0010));
    tick();
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = line_of(16'h0010);
    samp();
    tick();
    bus.pmem_resp  = 1'b0;
    exp_q.push_back(line_of(16'h0014));
    samp();
    chk("t3_inv_refill_hit", 128'(bus.imem_resp), 128'(1));

    // Invalidate in cycle 2 of a fill: line discarded, same address refetched.
    tick();
    req(16'h0120);
    samp();
    chk("t3_miss", 128'(bus.imem_resp), 128'(0));
    tick();
    samp();
    chk("t3_read", 128'(bus.pmem_read), 128'(1));
    tick();
    bus.invalidate = 1'b1;
    samp();
    chk("t3_inv_fill_resp", 128'(bus.imem_resp), 128'(0));
    tick();
    bus.invalidate = 1'b0;
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = line_of(16'h0120);
    samp();
    tick();
    bus.pmem_resp  = 1'b0;
    samp();
    chk("t3_dropped_resp", 128'(bus.imem_resp), 128'(0));
    chk("t3_dropped_rdata", bus.imem_rdata, 128'(0));
    tick();
    samp();
    chk("t3_refetch_read", 128'(bus.pmem_read), 128'(1));
    chk("t3_refetch_addr", 128'(bus.pmem_address), 128'(16'h0120));
    tick();
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = line_of(16'h0120);
    samp();
    tick();
    bus.pmem_resp  = 1'b0;
    exp_q.push_back(line_of(16'h0120));
    samp();
    chk("t3_refetch_hit", 128'(bus.imem_resp), 128'(1));

    // Invalidate coinciding with pmem_resp.
    tick();
    req(16'h0130);
    samp();
    tick();
    samp();
    chk("t3b_read", 128'(bus.pmem_read), 128'(1));
    tick();
    bus.invalidate = 1'b1;
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = line_of(16'h0130);
    samp();
    tick();
    bus.invalidate = 1'b0;
    bus.pmem_resp  = 1'b0;
    samp();
    chk("t3b_dropped_resp", 128'(bus.imem_resp), 128'(0));
    chk("t3b_dropped_rdata", bus.imem_rdata, 128'(0));
    tick();
    samp();
    chk("t3b_refetch_addr", 128'(bus.pmem_address), 128'(16'h0130));
    tick();
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = line_of(16'h0130);
    samp();
    tick();
    bus.pmem_resp  = 1'b0;
    exp_q.push_back(line_of(16'h0130));
    samp();
    chk("t3b_hit", 128'(bus.imem_resp), 128'(1));

    // Address change mid-fill.
    tick();
    req(16'h0040);
    samp();
    tick();
    samp();
    chk("t4_addr0", 128'(bus.pmem_address), 128'(16'h0040));
    tick();
    req(16'h0200);
    samp();
    chk("t4_addr_hold", 128'(bus.pmem_address), 128'(16'h0040));
    chk("t4_read_hold", 128'(bus.pmem_read), 128'(1));
    tick();
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = line_of(16'h0040);
    samp();
    chk("t4_addr_resp", 128'(bus.pmem_address), 128'(16'h0040));
    tick();
    bus.pmem_resp  = 1'b0;
    samp();
    chk("t4_new_miss", 128'(bus.imem_resp), 128'(0));
    chk("t4_line_stored", bus.imem_rdata, line_of(16'h0040));
    tick();
    samp();
    chk("t4_new_read", 128'(bus.pmem_read), 128'(1));
    chk("t4_new_addr", 128'(bus.pmem_address), 128'(16'h0200));
    tick();
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = line_of(16'h0200);
    samp();
    tick();
    bus.pmem_resp  = 1'b0;
    exp_q.push_back(line_of(16'h0200));
    samp();
    chk("t4_new_hit", 128'(bus.imem_resp), 128'(1));

    // Reset mid-fill, then a stray pmem_resp.
    tick();
    req(16'h0300);
    samp();
    tick();
    samp();
    chk("t5_read", 128'(bus.pmem_read), 128'(1));
    tick();
    reset_n = 1'b0;
    #1;
    chk("t5_rst_read", 128'(bus.pmem_read), 128'(0));
    chk("t5_rst_resp", 128'(bus.imem_resp), 128'(0));
    samp();
    chk("t5_rst_addr", 128'(bus.pmem_address), 128'(0));
    tick();
    reset_n = 1'b1;
    idle_bus();
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = line_of(16'h0300);
    samp();
    chk("t5_stray_read", 128'(bus.pmem_read), 128'(0));
    tick();
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
    samp();
    chk("t5_stray_rdata", bus.imem_rdata, 128'(0));
    miss_fill("t5_refill", 16'h0300, 2);

`ifdef ILB_PERF_CNT_EN
    tick();
    idle_bus();
    bus.perf_clear = 1'b1;
    samp();
    tick();
    bus.perf_clear = 1'b0;
    samp();
    chk("t6_clr_hit", 128'(bus.hit_count), 128'(0));
    miss_fill("t6_m", 16'h0400, 2);
    expect_hit("t6_h2", 16'h0402);
    expect_hit("t6_h3", 16'h0404);
    tick();
    idle_bus();
    samp();
    chk("t6_miss_cnt", 128'(bus.miss_count), 128'(1));
    chk("t6_hit_cnt", 128'(bus.hit_count), 128'(3));
    tick();
    req(16'h0400);
    bus.perf_clear = 1'b1;
    exp_q.push_back(line_of(16'h0400));
    samp();
    tick();
    bus.perf_clear = 1'b0;
    idle_bus();
    samp();
    chk("t6_clr_wins_hit", 128'(bus.hit_count), 128'(0));
    chk("t6_clr_wins_miss", 128'(bus.miss_count), 128'(0));
    mon_en = 1'b0;
    tick();
    req(16'h0400);
    repeat (65540) @(posedge clk);
    #1;
    idle_bus();
    samp();
    mon_en = 1'b1;
    chk("t6_hit_sat", 128'(bus.hit_count), 128'(16'hFFFF));
`endif

    tick();
    idle_bus();
    samp();
    chk("sb_drain", 128'(exp_q.size()), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
